pipe_stage_skid: RTL and testbench

Parametrised pipeline stage register with a valid/ready handshake, a two-entry skid buffer and synchronous flush. It is the general successor to the fixed ID/EX-style latch and sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Each stage carries a data bundle of LANES words and a control bundle. The stage can stall upstream without a combinational ready path, and can be flushed to inject bubbles on branch/jump mispredicts.

---
 rtl/pipe_stage_skid.sv | 164 ++++++++++++++++
 tb/tb_pipe_stage_skid.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
//
// Pipeline stage register with a valid/ready handshake and a two-entry skid
// buffer. The main entry drives the outputs; the skid entry catches the one
// beat that can arrive in the cycle after the stage stops being ready.
// Because of the skid entry, ready_o is a function of registered state (and
// the reset input) only, so no combinational ready path crosses the stage.
//
// A synchronous flush empties the stage and clears the stored control words,
// so a flushed stage presents a bubble (all control deasserted).
//
// Parameters:
//   DATA_W  width of one data lane
//   LANES   number of data lanes carried
//   CTRL_W  width of the control bundle
//
// Ports:
//   clk_i    clock, all state updates on the rising edge
//   rst_i    synchronous active-high reset
//   valid_i  upstream presents a beat
//   ready_o  stage can accept a beat this cycle
//   data_i   input lanes, lane k at [k*DATA_W +: DATA_W]
//   ctrl_i   input control bundle
//   valid_o  a beat is present at the output
//   ready_i  downstream accepts the output beat
//   data_o   output lanes (unmasked, stale when valid_o=0)
//   ctrl_o   output control, forced to zero when valid_o=0
//   flush_i  discard all held beats and the beat offered this cycle
//   occ_o    number of held entries (0, 1 or 2)
// -----------------------------------------------------------------------------
module pipe_stage_skid #(
  parameter int DATA_W = 32,
  parameter int LANES  = 5,
  parameter int CTRL_W = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic [LANES*DATA_W-1:0]   data_i,
  input  logic [CTRL_W-1:0]         ctrl_i,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [LANES*DATA_W-1:0]   data_o,
  output logic [CTRL_W-1:0]         ctrl_o,
  input  logic                      flush_i,
  output logic [1:0]                occ_o
);

  localparam int BUS_W = LANES * DATA_W;

  // State encoding equals the occupancy, so occ_o is the state register itself.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                valid_q, valid_d;
  logic [BUS_W-1:0]    main_data_q, main_data_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [BUS_W-1:0]    skid_data_q, skid_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;

  logic                in_fire;
  logic                out_fire;

  // ready_o looks only at the state register and reset, never at ready_i/valid_i.
  assign ready_o  = (state_q != ST_FULL) & ~rst_i;
  assign in_fire  = valid_i & ready_o;
  assign out_fire = valid_q & ready_i;

  // Next-state and storage update logic.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;

    if (flush_i) begin
      // Flush drops everything, including the beat offered this cycle.
      // Data may stay stale; control is cleared so no stale command survives.
      state_d     = ST_EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d     = ST_ONE;
            main_data_d = data_i;
            main_ctrl_d = ctrl_i;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            // Main drains and refills in the same cycle.
            state_d     = ST_ONE;
            main_data_d = data_i;
            main_ctrl_d = ctrl_i;
          end else if (in_fire) begin
            // Downstream stalled: park the newcomer in the skid entry.
            state_d     = ST_FULL;
            skid_data_d = data_i;
            skid_ctrl_d = ctrl_i;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_FULL: begin
          // ready_o is low here, so only the output side can move.
          if (out_fire) begin
            state_d     = ST_ONE;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
          end else begin
            state_d = ST_FULL;
          end
        end
        default: begin
          state_d     = ST_EMPTY;
          main_ctrl_d = '0;
          skid_ctrl_d = '0;
        end
      endcase
    end

    // valid_o is kept as its own flop so the output is a pure register.
    valid_d = (state_d != ST_EMPTY);
  end

  // State and storage registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_EMPTY;
      valid_q     <= 1'b0;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = main_data_q;
  assign occ_o   = state_q;
  // A bubble carries no control: one AND per bit behind the main register.
  assign ctrl_o  = main_ctrl_q & {CTRL_W{valid_q}};

endmodule

// File: tb/tb_pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_skid
//
// Bench for pipe_stage_skid. A queue-based model (a FIFO of depth two with
// flush and reset) predicts every output on every cycle; directed sequences
// add literal expectations on timing, ordering and the emitted beat stream.
// -----------------------------------------------------------------------------
module tb_pipe_stage_skid;

  localparam int DW = 32;
  localparam int LN = 5;
  localparam int CW = 8;
  localparam int BW = DW * LN;

  logic          clk;
  logic          rst_i;
  logic          valid_i;
  logic          ready_o;
  logic [BW-1:0] data_i;
  logic [CW-1:0] ctrl_i;
  logic          valid_o;
  logic          ready_i;
  logic [BW-1:0] data_o;
  logic [CW-1:0] ctrl_o;
  logic          flush_i;
  logic [1:0]    occ_o;

  int errors = 0;
  int checks = 0;

  pipe_stage_skid #(.DATA_W(DW), .LANES(LN), .CTRL_W(CW)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .ctrl_i  (ctrl_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o),
    .ctrl_o  (ctrl_o),
    .flush_i (flush_i),
    .occ_o   (occ_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generic comparison helper.
  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model: ordered FIFO of at most two beats -------
  typedef struct {
    logic [BW-1:0] data;
    logic [CW-1:0] ctrl;
  } beat_t;

  beat_t mq[$];
  logic  started   = 1'b0;
  logic  zero_flag = 1'b0;

  // Model update on each rising edge from the inputs seen at that edge.
  always @(posedge clk) begin
    started <= 1'b1;
    if (rst_i) begin
      mq.delete();
      zero_flag <= 1'b1;
    end else if (flush_i) begin
      mq.delete();
    end else if (valid_i && mq.size() < 2) begin
      if (mq.size() > 0 && ready_i) void'(mq.pop_front());
      mq.push_back('{data_i, ctrl_i});
      zero_flag <= 1'b0;
    end else if (mq.size() > 0 && ready_i) begin
      void'(mq.pop_front());
    end
  end

  // Cycle-by-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("valid_o", {191'd0, valid_o}, {191'd0, mq.size() != 0});
      chk("ready_o", {191'd0, ready_o}, {191'd0, (mq.size() < 2) && !rst_i});
      chk("occ_o", {190'd0, occ_o}, 192'(mq.size()));
      if (mq.size() != 0) begin
        chk("ctrl_o", {184'd0, ctrl_o}, {184'd0, mq[0].ctrl});
        chk("data_o", {32'd0, data_o}, {32'd0, mq[0].data});
      end else begin
        chk("ctrl_o_bubble", {184'd0, ctrl_o}, 192'd0);
        if (zero_flag) chk("data_o_after_reset", {32'd0, data_o}, 192'd0);
      end
    end
  end

  // Log of lane 0 of every beat accepted downstream.
  logic [31:0] emitted[$];
  always @(posedge clk) begin
    if (!rst_i && valid_o && ready_i) emitted.push_back(data_o[31:0]);
  end

  // One clock; leaves time at negedge+1 so outputs are settled and inputs may change.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [31:0] lane0);
    valid_i      = v;
    data_i       = '0;
    data_i[31:0] = lane0;
  endtask

  initial begin
    rst_i   = 1'b1;
    flush_i = 1'b0;
    ready_i = 1'b1;
    ctrl_i  = 8'h3C;
    offer(1'b1, 32'hDEADBEEF);

    // Reset held for two cycles with a beat offered.
    tick();
    chk("rst_ready_low", {191'd0, ready_o}, 192'd0);
    chk("rst_valid_low", {191'd0, valid_o}, 192'd0);
    tick();
    chk("rst_ready_low2", {191'd0, ready_o}, 192'd0);
    rst_i = 1'b0;
    offer(1'b0, 32'd0);
    #1;
    chk("post_rst_ready", {191'd0, ready_o}, 192'd1);
    chk("post_rst_occ", {190'd0, occ_o}, 192'd0);
    chk("post_rst_data", {32'd0, data_o}, 192'd0);
    chk("rst_nothing_emitted", 192'(emitted.size()), 192'd0);
    tick();

    // Streaming: eight beats with downstream always ready.
    emitted.delete();
    ctrl_i = 8'hA5;
    for (int i = 1; i <= 8; i++) begin
      offer(1'b1, 32'(i));
      tick();
      chk("stream_data", {160'd0, data_o[31:0]}, 192'(i));
      chk("stream_ctrl", {184'd0, ctrl_o}, 192'hA5);
      chk("stream_occ", {190'd0, occ_o}, 192'd1);
    end
    offer(1'b0, 32'd0);
    tick();
    chk("stream_drained", {191'd0, valid_o}, 192'd0);
    chk("stream_count", 192'(emitted.size()), 192'd8);
    for (int i = 0; i < emitted.size(); i++)
      chk("stream_order", {160'd0, emitted[i]}, 192'(i + 1));

    // Stall and skid: three beats pushed against a stalled downstream.
    emitted.delete();
    ready_i = 1'b0;
    offer(1'b1, 32'h10);
    tick();
    chk("skid_occ1", {190'd0, occ_o}, 192'd1);
    chk("skid_ready1", {191'd0, ready_o}, 192'd1);
    offer(1'b1, 32'h11);
    tick();
    chk("skid_occ2", {190'd0, occ_o}, 192'd2);
    chk("skid_ready0", {191'd0, ready_o}, 192'd0);
    offer(1'b1, 32'h12);
    tick();
    tick();
    chk("skid_hold_data", {160'd0, data_o[31:0]}, 192'h10);
    chk("skid_hold_occ", {190'd0, occ_o}, 192'd2);
    ready_i = 1'b1;
    tick();
    chk("skid_release_data", {160'd0, data_o[31:0]}, 192'h11);
    tick();
    chk("skid_last_data", {160'd0, data_o[31:0]}, 192'h12);
    offer(1'b0, 32'd0);
    tick();
    chk("skid_count", 192'(emitted.size()), 192'd3);
    for (int i = 0; i < emitted.size(); i++)
      chk("skid_order", {160'd0, emitted[i]}, 192'(32'h10 + i));

    // Flush while full with a beat offered.
    emitted.delete();
    ready_i = 1'b0;
    offer(1'b1, 32'h30);
    tick();
    offer(1'b1, 32'h31);
    tick();
    chk("pre_flush_occ", {190'd0, occ_o}, 192'd2);
    offer(1'b1, 32'h99);
    flush_i = 1'b1;
    tick();
    chk("flush_valid", {191'd0, valid_o}, 192'd0);
    chk("flush_ctrl", {184'd0, ctrl_o}, 192'd0);
    chk("flush_occ", {190'd0, occ_o}, 192'd0);
    chk("flush_ready", {191'd0, ready_o}, 192'd1);
    flush_i = 1'b0;
    offer(1'b0, 32'd0);
    ready_i = 1'b1;
    tick();
    tick();
    chk("flush_nothing_emitted", 192'(emitted.size()), 192'd0);

    // Simultaneous accept and emit while holding one beat.
    emitted.delete();
    ready_i = 1'b0;
    offer(1'b1, 32'h20);
    tick();
    ready_i = 1'b1;
    offer(1'b1, 32'h21);
    tick();
    chk("simul_valid", {191'd0, valid_o}, 192'd1);
    chk("simul_data", {160'd0, data_o[31:0]}, 192'h21);
    chk("simul_occ", {190'd0, occ_o}, 192'd1);
    offer(1'b0, 32'd0);
    tick();
    chk("simul_count", 192'(emitted.size()), 192'd2);
    if (emitted.size() == 2) begin
      chk("simul_first", {160'd0, emitted[0]}, 192'h20);
      chk("simul_second", {160'd0, emitted[1]}, 192'h21);
    end

    // Random traffic with flushes and occasional resets, checked by the model.
    for (int c = 0; c < 4000; c++) begin
      valid_i = ($urandom_range(0, 99) < 70);
      ready_i = ($urandom_range(0, 99) < 60);
      flush_i = ($urandom_range(0, 99) < 5);
      rst_i   = ($urandom_range(0, 999) < 5);
      data_i  = {$urandom, $urandom, $urandom, $urandom, $urandom};
      ctrl_i  = 8'($urandom);
      tick();
    end

    rst_i   = 1'b0;
    flush_i = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    tick();
    tick();
    tick();
    chk("final_empty", {190'd0, occ_o}, 192'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
